serial_add_seq: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares one external full adder (FA: a, b, c_in -> s, c_out) across all WIDTH bits of an operand pair.
- Captures the operands on a start request and feeds the FA one bit per clock, LSB first.
- Holds the running carry in a flop and assembles the sum in a shift register.
- Reports completion with a one-cycle done pulse, plus carry-out and signed overflow.

---
 rtl/serial_add_seq.sv | 125 ++++++++++++
 tb/tb_serial_add_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: drives one external full adder LSB-first,
// one bit per clock, and collects the sum, carry-out and signed overflow.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_step;
   logic             w_last;
   logic [WIDTH:0]   w_sum_cat;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: every output of this block gets a default first, so no latches.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_last       = (r_cnt == CW'(WIDTH - 1));
      busy         = 1'b0;
      done         = 1'b0;
      fa_a         = 1'b0;
      fa_b         = 1'b0;
      fa_cin       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            fa_a   = r_a_sh[0];
            fa_b   = r_b_sh[0];
            fa_cin = r_carry;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // FA sum bit enters at the MSB; after WIDTH steps bit 0 lands at sum[0].
   assign w_sum_cat = {fa_s, r_sum};

   // NOTE: operand shifters are reset too, so an aborted run leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sh  <= op_a;
         r_b_sh  <= sub ? ~op_b : op_b;
         r_carry <= sub;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_step) begin
         r_sum   <= w_sum_cat[WIDTH:1];
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_carry <= fa_cout;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            // r_carry holds the carry into the MSB on the last step.
            r_cout <= fa_cout;
            r_ovf  <= r_carry ^ fa_cout;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: an 8-bit and a 1-bit instance,
// each driving a behavioural full adder.
module tb_serial_add_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         busy, done, cout, ovf, fa_a, fa_b, fa_cin, fa_s, fa_cout;
   logic [W-1:0] sum;

   logic start1 = 1'b0;
   logic sub1 = 1'b0;
   logic a1 = 1'b0;
   logic b1 = 1'b0;
   logic busy1, done1, sum1, cout1, ovf1, fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;

   always #5 clk = ~clk;

   assign fa_s     = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout  = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
   assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
   assign fa_cout1 = (fa_a1 & fa_b1) | (fa_cin1 & (fa_a1 ^ fa_b1));

   serial_add_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
   );

   serial_add_seq #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .op_a(a1), .op_b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at the first negedge after the accepting edge; returns how many
   // cycles (counted from that point, starting at 1) until done is seen.
   task automatic wait_done(output int lat, output int bc);
      lat = 1;
      bc  = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bc);
      @(negedge clk);
      start = 1'b1; sub = s; op_a = a; op_b = b;
      @(negedge clk);
      // Scramble inputs after acceptance; they must have no effect.
      start = 1'b0; sub = ~s; op_a = ~a; op_b = ~b;
      wait_done(lat, bc);
   endtask

   typedef struct {
      string        name;
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, bc, done_cnt;

      vecs[0] = '{"add_3c_05", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
      vecs[1] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{"sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{"add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{"sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{"add_64_64", 1'b0, 8'h64, 8'h64, 8'hC8, 1'b0, 1'b1};

      // Reset state, sampled while reset is still asserted.
      #12;
      check("rst.busy",  32'(busy), 32'd0);
      check("rst.done",  32'(done), 32'd0);
      check("rst.sum",   32'(sum), 32'd0);
      check("rst.cout",  32'(cout), 32'd0);
      check("rst.ovf",   32'(ovf), 32'd0);
      check("rst.fa",    32'({fa_a, fa_b, fa_cin}), 32'd0);
      check("rst1.outs", 32'({busy1, done1, sum1, cout1, ovf1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle.busy", 32'(busy), 32'd0);
      check("idle.fa",   32'({fa_a, fa_b, fa_cin}), 32'd0);

      // Table-driven arithmetic vectors.
      foreach (vecs[i]) begin
         run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat, bc);
         check($sformatf("%s.latency", vecs[i].name), 32'(lat), 32'd9);
         check($sformatf("%s.busy_cycles", vecs[i].name), 32'(bc), 32'd8);
         check($sformatf("%s.sum", vecs[i].name), 32'(sum), 32'(vecs[i].sum));
         check($sformatf("%s.cout", vecs[i].name), 32'(cout), 32'(vecs[i].cout));
         check($sformatf("%s.ovf", vecs[i].name), 32'(ovf), 32'(vecs[i].ovf));
         @(negedge clk);
         check($sformatf("%s.done_pulse", vecs[i].name), 32'(done), 32'd0);
         check($sformatf("%s.idle_fa", vecs[i].name), 32'({fa_a, fa_b, fa_cin}), 32'd0);
         check($sformatf("%s.sum_hold", vecs[i].name), 32'(sum), 32'(vecs[i].sum));
      end

      // Start requests during RUN (cycle 3) and DONE (cycle 9) are ignored.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; op_a = 8'h10; op_b = 8'h20;
      done_cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (k == 9) check("ign.done_at_9", 32'(done), 32'd1);
         start = (k == 3 || k == 9);
         op_a  = start ? 8'hAA : 8'h00;
         op_b  = 8'h55;
      end
      @(negedge clk);
      if (done) done_cnt++;
      check("ign.busy_after", 32'(busy), 32'd0);
      check("ign.sum", 32'(sum), 32'h30);
      check("ign.done_count", 32'(done_cnt), 32'd1);
      start = 1'b1; sub = 1'b0; op_a = 8'h01; op_b = 8'h02;
      @(negedge clk);
      start = 1'b0;
      check("next.accepted", 32'(busy), 32'd1);
      wait_done(lat, bc);
      check("next.latency", 32'(lat), 32'd9);
      check("next.sum", 32'(sum), 32'h03);

      // Asynchronous reset after 4 RUN edges aborts the operation.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; op_a = 8'hFF; op_b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort.pre_sum", 32'(sum), 32'hE0);
      check("abort.pre_fa_a", 32'(fa_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.sum",  32'(sum), 32'd0);
      check("abort.fa",   32'({fa_a, fa_b, fa_cin}), 32'd0);
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort.no_done", 32'(done_cnt), 32'd0);
      run_op(1'b0, 8'h01, 8'h01, lat, bc);
      check("post_rst.latency", 32'(lat), 32'd9);
      check("post_rst.sum", 32'(sum), 32'h02);

      // WIDTH=1 instance: 1+1 and 1-0.
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      check("w1_add.busy", 32'(busy1), 32'd1);
      lat = 1;
      while (!done1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("w1_add.latency", 32'(lat), 32'd2);
      check("w1_add.sum",  32'(sum1), 32'd0);
      check("w1_add.cout", 32'(cout1), 32'd1);
      check("w1_add.ovf",  32'(ovf1), 32'd1);
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; sub1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b1; sub1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("w1_sub.latency", 32'(lat), 32'd2);
      check("w1_sub.sum",  32'(sum1), 32'd1);
      check("w1_sub.cout", 32'(cout1), 32'd1);
      check("w1_sub.ovf",  32'(ovf1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
